// File: rtl/bus_timeout_if.sv
// bus_timeout_if
// Groups the CPU-side memory request and the decode-side handshake that the
// watchdog sits between.
//   master : the environment (CPU + address decode); drives the request and
//            the decode response, observes the watchdog outputs.
//   slave  : the watchdog; consumes the request/response and produces the
//            CPU acknowledge and the gated request valid.
// Signals:
//   cpu_valid, cpu_addr[31:0], cpu_instr, cpu_wstrb[3:0] : CPU request
//   cpu_ready, cpu_rdata[31:0]                            : CPU response
//   slave_valid                                           : gated valid to decode
//   slave_ready, slave_rdata[31:0]                        : decode response
interface bus_timeout_if;
    logic        cpu_valid;
    logic [31:0] cpu_addr;
    logic        cpu_instr;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        slave_valid;
    logic        slave_ready;
    logic [31:0] slave_rdata;

    modport master (
        output cpu_valid, cpu_addr, cpu_instr, cpu_wstrb, slave_ready, slave_rdata,
        input  cpu_ready, cpu_rdata, slave_valid
    );

    modport slave (
        input  cpu_valid, cpu_addr, cpu_instr, cpu_wstrb, slave_ready, slave_rdata,
        output cpu_ready, cpu_rdata, slave_valid
    );
endinterface

// File: rtl/bus_timeout.sv
// bus_timeout
// Watchdog between the CPU memory port and the address decode. Requests pass
// through combinationally; a request left unacknowledged for `limit` cycles
// is aborted (CPU gets ready with rdata 0) and the fault is recorded in a
// small MMIO register bank.
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   bus               : bus_timeout_if.slave (CPU request + decode response)
//   timeout_event     : one-cycle pulse during each abort
//   cs, we, address,
//   write_data        : MMIO request (word address)
//   read_data, ready  : MMIO response, registered, one cycle after cs
module bus_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    bus_timeout_if.slave  bus,
    output logic          timeout_event,
    input  logic          cs,
    input  logic          we,
    input  logic [7:0]    address,
    input  logic [31:0]   write_data,
    output logic [31:0]   read_data,
    output logic          ready
);

    typedef enum logic [1:0] {IDLE, WAIT, ABORT, DRAIN} state_t;

    localparam logic [7:0] ADDR_STATUS      = 8'h08;
    localparam logic [7:0] ADDR_CTRL        = 8'h09;
    localparam logic [7:0] ADDR_FAULT_ADDR  = 8'h0a;
    localparam logic [7:0] ADDR_FAULT_INFO  = 8'h0b;
    localparam logic [7:0] ADDR_FAULT_COUNT = 8'h0c;
    localparam logic [7:0] ADDR_LIMIT       = 8'h0d;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] active_limit;
    logic [15:0] limit;
    logic        enable;
    logic        status_timeout;
    logic [31:0] fault_addr;
    logic [7:0]  fault_info;
    logic [15:0] fault_count;
    logic [31:0] read_mux;
    logic        ctrl_write;
    logic        limit_write;
    logic        clear_req;
    logic        unused_write_bits;

    assign ctrl_write        = cs && we && (address == ADDR_CTRL);
    assign limit_write       = cs && we && (address == ADDR_LIMIT);
    assign clear_req         = ctrl_write && write_data[1];
    assign unused_write_bits = ^write_data[31:16];

    // The limit is captured on entry to WAIT so a LIMIT write never changes
    // the deadline of a request already being timed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= 16'd0;
            active_limit  <= TIMEOUT_CYCLES[15:0];
            timeout_event <= 1'b0;
        end else begin
            timeout_event <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpu_valid && enable && !bus.slave_ready) begin
                        state        <= WAIT;
                        cnt          <= 16'd1;
                        active_limit <= limit;
                    end else begin
                        cnt <= 16'd0;
                    end
                end
                WAIT: begin
                    // A late ready on the deadline cycle still completes normally.
                    if (bus.slave_ready || !bus.cpu_valid) begin
                        state <= IDLE;
                        cnt   <= 16'd0;
                    end else if (cnt == active_limit - 16'd1) begin
                        state         <= ABORT;
                        cnt           <= 16'd0;
                        timeout_event <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ABORT:   state <= DRAIN;
                DRAIN:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ABORT answers the CPU itself; DRAIN swallows any straggling decode
    // acknowledge so it cannot complete the CPU's next request.
    always_comb begin
        bus.slave_valid = bus.cpu_valid;
        bus.cpu_ready   = bus.slave_ready;
        bus.cpu_rdata   = bus.slave_rdata;
        case (state)
            ABORT: begin
                bus.slave_valid = 1'b0;
                bus.cpu_ready   = 1'b1;
                bus.cpu_rdata   = 32'h0000_0000;
            end
            DRAIN: begin
                bus.slave_valid = 1'b0;
                bus.cpu_ready   = 1'b0;
            end
            default: ;
        endcase
    end

    // A fault recorded in the same cycle as a clear survives: the clear wipes
    // the old history and the new fault becomes the first entry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable         <= 1'b1;
            limit          <= TIMEOUT_CYCLES[15:0];
            status_timeout <= 1'b0;
            fault_addr     <= 32'h0;
            fault_info     <= 8'h0;
            fault_count    <= 16'h0;
        end else begin
            if (ctrl_write) begin
                enable <= write_data[0];
            end
            if (limit_write) begin
                limit <= (write_data[15:0] < 16'd2) ? 16'd2 : write_data[15:0];
            end
            if (state == ABORT) begin
                status_timeout <= 1'b1;
                fault_addr     <= bus.cpu_addr;
                fault_info     <= {bus.cpu_wstrb, 3'b000, bus.cpu_instr};
                if (clear_req) begin
                    fault_count <= 16'd1;
                end else if (fault_count != 16'hFFFF) begin
                    fault_count <= fault_count + 16'd1;
                end
            end else if (clear_req) begin
                status_timeout <= 1'b0;
                fault_addr     <= 32'h0;
                fault_info     <= 8'h0;
                fault_count    <= 16'h0;
            end
        end
    end

    always_comb begin
        read_mux = 32'h0;
        case (address)
            ADDR_STATUS:      read_mux = {30'h0, enable, status_timeout};
            ADDR_CTRL:        read_mux = {31'h0, enable};
            ADDR_FAULT_ADDR:  read_mux = fault_addr;
            ADDR_FAULT_INFO:  read_mux = {24'h0, fault_info};
            ADDR_FAULT_COUNT: read_mux = {16'h0, fault_count};
            ADDR_LIMIT:       read_mux = {16'h0, limit};
            default:          read_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready     <= 1'b0;
            read_data <= 32'h0;
        end else begin
            ready     <= cs;
            read_data <= (cs && !we) ? read_mux : 32'h0;
        end
    end

endmodule

// File: doc/bus_timeout.md
# bus_timeout

Watchdog stage inserted between the picorv32 memory port and the top-level address decode/mux. It forwards every CPU bus request to the decode unchanged and with zero added latency. If a request is not acknowledged within a programmable number of cycles, it aborts the request: it returns an illegal instruction (0x00000000) to the CPU and records the fault. It also exposes a small MMIO register bank, so firmware can read and clear fault information through the standard core cs/we/address interface.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: reset value of the cycle limit; legal range 2..65535.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low; clock clk.
- cpu_valid  in  1  request valid from the CPU.
- cpu_addr  in  32  request address from the CPU.
- cpu_instr  in  1  request is an instruction fetch.
- cpu_wstrb  in  4  write strobes; 0 means a read.
- cpu_ready  out  1  acknowledge to the CPU.
- cpu_rdata  out  32  read data to the CPU.
- slave_valid  out  1  gated valid to the decode.
- slave_ready  in  1  registered ready from the decode.
- slave_rdata  in  32  registered read data from the decode.
- timeout_event  out  1  one-cycle pulse on each abort.
- cs  in  1  MMIO select.
- we  in  1  MMIO write.
- address  in  8  MMIO word address.
- write_data  in  32  MMIO write data.
- read_data  out  32  MMIO read data.
- ready  out  1  MMIO acknowledge.

## Operation
State machine: IDLE, WAIT, ABORT, DRAIN.
- IDLE: slave_valid = cpu_valid. cpu_ready = slave_ready. cpu_rdata = slave_rdata. If cpu_valid && enable && !slave_ready: go to WAIT, cnt <= 1.
- WAIT: pass-through as in IDLE, cnt increments by 1 per cycle.
  - slave_ready=1: go to IDLE (normal completion).
  - cpu_valid=0: go to IDLE.
  - cnt == limit-1 && !slave_ready: go to ABORT.
- ABORT (1 cycle):
  - slave_valid=0, cpu_ready=1, cpu_rdata=0x00000000, timeout_event=1.
  - Latch fault_addr=cpu_addr and fault_info={cpu_wstrb[3:0] at bits 7:4, cpu_instr at bit 0}.
  - Set sticky status.timeout; fault_count increments, saturating at 0xFFFF.
  - Go to DRAIN.
- DRAIN (1 cycle): slave_valid=0, cpu_ready=0; any slave_ready is discarded; go to IDLE.
- enable=0: remain in IDLE (pure pass-through); cnt is held at 0.
- Simultaneous slave_ready and limit reached: slave_ready wins and no abort is taken.
- Abort happens exactly `limit` cycles after the first cycle of cpu_valid.

MMIO registers (word addresses):
- 0x08 STATUS, RO: bit0 = timeout sticky, bit1 = enable.
- 0x09 CTRL, RW:
  - bit0 = enable, reset value 1.
  - Writing 1 to bit1 clears STATUS.timeout, fault_count, fault_addr and fault_info; bit1 reads 0.
- 0x0a FAULT_ADDR, RO.
- 0x0b FAULT_INFO, RO.
- 0x0c FAULT_COUNT, RO: 16 bits, zero-extended.
- 0x0d LIMIT, RW, 16 bits:
  - Writes of 0 or 1 are stored as 2.
  - A write takes effect from the next transaction that enters WAIT.
- Other addresses: reads return 0; writes are ignored.

Boundary conditions:
- A clear and an abort in the same cycle: the abort wins; status=1 and count=1.
- A CPU write is not performed if aborted: slave_valid drops from ABORT onward.

## Timing
- Pass-through path is combinational: completion latency equals the decode latency.
- MMIO: ready and read_data are registered, asserted the cycle after cs=1. ready is a single-cycle pulse per cs cycle.
- Reset values:
  - state=IDLE, cnt=0.
  - timeout_event=0, ready=0, read_data=0.
  - enable=1, limit=TIMEOUT_CYCLES.
  - status, fault_addr, fault_info and fault_count = 0.
  - cpu_ready and slave_valid follow the IDLE pass-through from the first cycle out of reset.
- Reset asserted mid-WAIT or mid-ABORT: next cycle is IDLE with no pulse and no fault recorded.

## Test plan
- Read with slave_ready after 3 cycles, limit 64: cpu_ready on cycle 3, cpu_rdata=slave_rdata, no timeout_event, FAULT_COUNT=0.
- slave_ready never asserted, limit 4, cpu_addr=0xC5000010, wstrb=0, instr=1:
  - slave_valid drops after 4 cycles; cpu_ready=1 with rdata 0 for one cycle; timeout_event pulses once.
  - FAULT_ADDR=0xC5000010, FAULT_INFO=0x1, STATUS=0x3, FAULT_COUNT=1.
- slave_ready arrives exactly on the limit cycle: normal completion with slave data; no abort.
- Write LIMIT=0: readback is 2. Write CTRL=0x0: a hung access never aborts and cnt stays 0.
- 0xFFFF consecutive aborts followed by one more: FAULT_COUNT stays 0xFFFF. A CTRL write of 0x3 in the same cycle as an abort leaves STATUS.timeout=1 and FAULT_COUNT=1.
- reset_n low for 1 cycle during WAIT: returns to IDLE; no timeout_event; registers at reset values.
